// File: rtl/sseg_share_ctrl.sv
// sseg_share_ctrl: shares a 4-digit multiplexed 7-segment display between two
// req/gnt clients.
//   - Round-robin arbitration with a minimum ownership time (HOLD_CYC).
//   - Free-running digit scan: 2^SLOT_W cycles per digit slot, four slots per frame.
//   - Every slot starts with BLANK_CYC dark cycles to suppress ghosting.
//   - The owner's pattern is snapshotted into a shadow register only at grant
//     time and at frame boundaries, so a frame is never torn.
// Optional build macro DISP_ACTIVE_LOW_EN: invert an/sseg at the output
// registers for common-anode boards. gnt and frame keep their polarity.
module sseg_share_ctrl #(
    parameter int SLOT_W    = 16,
    parameter int BLANK_CYC = 64,
    parameter int HOLD_CYC  = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    output logic [1:0]  gnt,
    output logic [3:0]  an,
    output logic [7:0]  sseg,
    output logic        frame
);

    localparam int HOLD_W = $clog2(HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC);

`ifdef DISP_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif
    localparam logic [3:0] AN_DARK  = {4{INV}};
    localparam logic [7:0] SEG_DARK = {8{INV}};

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t             state;
    logic [SLOT_W-1:0]  slot_cnt;
    logic [1:0]         digit;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [31:0]        shadow;
    logic               ptr;        // 0: client 0 preferred on a tie

    logic               slot_wrap;
    logic               frame_bnd;
    logic               blank;
    logic               own;        // index of the current owner (valid in OWNx)
    logic               other_req;
    logic               own_req;
    logic [31:0]        own_data;
    logic [31:0]        other_data;
    logic               idle_pick;  // client granted from IDLE

    assign slot_wrap  = &slot_cnt;
    assign frame_bnd  = slot_wrap && (digit == 2'd3);
    assign blank      = (32'(slot_cnt) < BLANK_CYC);
    assign own        = (state == OWN1);
    assign own_req    = own ? req[1] : req[0];
    assign other_req  = own ? req[0] : req[1];
    assign own_data   = own ? data1 : data0;
    assign other_data = own ? data0 : data1;
    assign idle_pick  = (req == 2'b11) ? ptr : req[1];

    // Free-running scan counters and the frame pulse (one cycle after the boundary).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            digit    <= 2'd0;
            frame    <= 1'b0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_wrap)
                digit <= digit + 2'd1;
            frame <= frame_bnd;
        end
    end

    // Registered digit drive: dark when unowned or inside the blanking window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an   <= AN_DARK;
            sseg <= SEG_DARK;
        end else if (state == IDLE || blank) begin
            an   <= AN_DARK;
            sseg <= SEG_DARK;
        end else begin
            an   <= (4'b0001 << digit) ^ AN_DARK;
            sseg <= shadow[8*digit +: 8] ^ SEG_DARK;
        end
    end

    // Ownership FSM: grant, hold timing, frame-aligned preemption and shadow capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            hold_cnt <= '0;
            shadow   <= '0;
            ptr      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        state    <= idle_pick ? OWN1 : OWN0;
                        gnt      <= idle_pick ? 2'b10 : 2'b01;
                        hold_cnt <= '0;
                        shadow   <= idle_pick ? data1 : data0;
                    end
                end
                OWN0, OWN1: begin
                    if (!own_req) begin
                        // Release wins over everything, including a frame boundary.
                        state <= IDLE;
                        gnt   <= 2'b00;
                        ptr   <= ~own;
                    end else if (other_req && hold_cnt == HOLD_MAX && frame_bnd) begin
                        // Preempt only on a frame edge so the new owner starts at digit 0.
                        state    <= own ? OWN0 : OWN1;
                        gnt      <= own ? 2'b01 : 2'b10;
                        shadow   <= other_data;
                        hold_cnt <= '0;
                        ptr      <= own;
                    end else begin
                        if (hold_cnt != HOLD_MAX)
                            hold_cnt <= hold_cnt + 1'b1;
                        if (frame_bnd)
                            shadow <= own_data;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sseg_share_ctrl.sv
// Self-checking bench for sseg_share_ctrl (SLOT_W=3, BLANK_CYC=2, HOLD_CYC=40).
// A cycle-indexed behavioural model predicts gnt/an/sseg/frame from elapsed
// time and an owner/age/shadow view. Directed phases pin the model with
// literal values; a random phase follows.
module tb_sseg_share_ctrl;

    localparam int SLOT_W = 3;
    localparam int BLANK  = 2;
    localparam int HOLD   = 40;
    localparam int SLOT_N = 1 << SLOT_W;

`ifdef DISP_ACTIVE_LOW_EN
    localparam logic [3:0] AN_INV  = 4'hF;
    localparam logic [7:0] SEG_INV = 8'hFF;
`else
    localparam logic [3:0] AN_INV  = 4'h0;
    localparam logic [7:0] SEG_INV = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [31:0] data0 = 32'h0;
    logic [31:0] data1 = 32'h0;
    logic [1:0]  gnt;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        frame;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    sseg_share_ctrl #(.SLOT_W(SLOT_W), .BLANK_CYC(BLANK), .HOLD_CYC(HOLD)) dut (
        .clk(clk), .reset(reset), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt), .an(an), .sseg(sseg), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int          mn;      // cycles elapsed since reset release
    int          m_own;   // -1 none, else client index
    int          m_age;   // cycles owned
    int          m_ptr;
    logic [31:0] m_sh;
    logic [1:0]  e_gnt;
    logic [3:0]  e_an;
    logic [7:0]  e_sseg;
    logic        e_frame;

    always @(posedge clk or posedge reset) begin : model
        int slot, dig;
        bit fb;
        if (reset) begin
            mn = 0; m_own = -1; m_age = 0; m_ptr = 0; m_sh = 0;
            e_gnt = 2'b00; e_an = AN_INV; e_sseg = SEG_INV; e_frame = 1'b0;
        end else begin
            slot = mn % SLOT_N;
            dig  = (mn / SLOT_N) % 4;
            fb   = (slot == SLOT_N - 1) && (dig == 3);
            e_frame = fb;
            if (m_own < 0 || slot < BLANK) begin
                e_an = AN_INV; e_sseg = SEG_INV;
            end else begin
                e_an   = 4'(1 << dig) ^ AN_INV;
                e_sseg = m_sh[8*dig +: 8] ^ SEG_INV;
            end
            if (m_own < 0) begin
                if (req != 2'b00) begin
                    m_own = (req == 2'b11) ? m_ptr : (req[1] ? 1 : 0);
                    m_age = 0;
                    m_sh  = (m_own == 1) ? data1 : data0;
                end
            end else if (!req[m_own]) begin
                m_ptr = 1 - m_own;
                m_own = -1;
            end else if (req[1-m_own] && m_age >= HOLD && fb) begin
                m_ptr = m_own;
                m_own = 1 - m_own;
                m_age = 0;
                m_sh  = (m_own == 1) ? data1 : data0;
            end else begin
                m_age++;
                if (fb) m_sh = (m_own == 1) ? data1 : data0;
            end
            e_gnt = (m_own < 0) ? 2'b00 : ((m_own == 1) ? 2'b10 : 2'b01);
            mn++;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("an", 32'(an), 32'(e_an));
            chk("sseg", 32'(sseg), 32'(e_sseg));
            chk("frame", 32'(frame), 32'(e_frame));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int fcount;
        int k;
        bit seen;

        // Reset state
        #2;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_an", 32'(an), 32'(AN_INV));
        chk("rst_sseg", 32'(sseg), 32'(SEG_INV));
        chk("rst_frame", 32'(frame), 32'h0);
        step(3);
        reset = 1'b0;
        chk_en = 1'b1;

        // Idle scan: dark, frame every 32 cycles
        fcount = 0;
        repeat (100) begin
            @(negedge clk);
            if (frame) fcount++;
        end
        chk("idle_frame_count", 32'(fcount), 32'd3);
        chk("idle_gnt", 32'(gnt), 32'h0);

        // Client 0 grant and digit sequence
        req = 2'b01; data0 = 32'h44332211;
        step(1);
        chk("grant0", 32'(gnt), 32'h1);
        seen = 0;
        for (k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            seen = frame;
        end
        chk("frame_seen", 32'(seen), 32'h1);
        step(1);
        chk("blank_an", 32'(an), 32'(AN_INV));
        step(2);
        chk("d0_an", 32'(an), 32'(4'b0001 ^ AN_INV));
        chk("d0_seg", 32'(sseg), 32'(8'h11 ^ SEG_INV));
        step(8);
        chk("d1_an", 32'(an), 32'(4'b0010 ^ AN_INV));
        chk("d1_seg", 32'(sseg), 32'(8'h22 ^ SEG_INV));
        data0 = 32'hAABBCCDD;
        step(8);
        chk("d2_old_seg", 32'(sseg), 32'(8'h33 ^ SEG_INV));
        step(8);
        chk("d3_old_seg", 32'(sseg), 32'(8'h44 ^ SEG_INV));
        step(8);
        chk("new_frame_an", 32'(an), 32'(4'b0001 ^ AN_INV));
        chk("new_frame_seg", 32'(sseg), 32'(8'hDD ^ SEG_INV));

        // Fresh ownership by client 0, client 1 waits for hold + frame edge
        req = 2'b00;
        step(1);
        chk("release_gnt", 32'(gnt), 32'h0);
        step($urandom_range(0, 20));
        req = 2'b01; data1 = 32'h0F0E0D0C;
        step(5);
        req = 2'b11;
        seen = 0;
        for (k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = (gnt == 2'b10);
        end
        chk("preempt_seen", 32'(seen), 32'h1);
        chk("preempt_at_frame", 32'(frame), 32'h1);

        // Both requests out of reset: pointer picks client 0, then hand-over
        @(negedge clk);
        reset = 1'b1; req = 2'b11;
        step(2);
        reset = 1'b0;
        step(1);
        chk("tie_gnt", 32'(gnt), 32'h1);
        req = 2'b10;
        step(1);
        chk("drop0_idle", 32'(gnt), 32'h0);
        step(1);
        chk("grant1", 32'(gnt), 32'h2);

        // Asynchronous reset while client 1 is lit mid-slot
        seen = 0;
        for (k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = (an != AN_INV);
        end
        chk("own1_lit", 32'(seen), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("async_an", 32'(an), 32'(AN_INV));
        chk("async_sseg", 32'(sseg), 32'(SEG_INV));
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_frame", 32'(frame), 32'h0);
        step(2);
        reset = 1'b0;

        // Random traffic against the model
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) req[0] = ~req[0];
            if ($urandom_range(0, 39) == 0) req[1] = ~req[1];
            if ($urandom_range(0, 9) == 0) data0 = $urandom;
            if ($urandom_range(0, 9) == 0) data1 = $urandom;
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
